// File: rtl/serial_char_compare.sv
// Bit-serial MSB-first magnitude comparator feeding the insertion-sort swap decision.
// Optional early-result mode: define SERIAL_CMP_EARLY_DONE_EN.
module serial_char_compare #(
   parameter int W = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       St,
   input  logic       R,
   input  logic       x,
   input  logic       y,
   output logic       Busy,
   output logic       Done,
   output logic       LT,
   output logic       EQ,
   output logic       GT,
   output logic       Swap,
   output logic [1:0] state_dbg
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            lt_sf;
   logic            gt_sf;
   logic            undecided;
   logic            lt_nx;
   logic            gt_nx;
`ifdef SERIAL_CMP_EARLY_DONE_EN
   logic            first_diff;
`endif

   // Only the first differing bit (MSB first) decides; later bits are ignored.
   always_comb begin
      undecided = ~(lt_sf | gt_sf);
      lt_nx     = lt_sf | (undecided & ~x & y);
      gt_nx     = gt_sf | (undecided & x & ~y);
`ifdef SERIAL_CMP_EARLY_DONE_EN
      first_diff = undecided & (x ^ y);
`endif
   end

   assign state_dbg = state;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
         lt_sf <= 1'b0;
         gt_sf <= 1'b0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         LT    <= 1'b0;
         EQ    <= 1'b1;
         GT    <= 1'b0;
         Swap  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (St && R) begin
                  state <= CMP;
                  cnt   <= CW'(W - 1);
                  lt_sf <= 1'b0;
                  gt_sf <= 1'b0;
                  Busy  <= 1'b1;
               end
            end
            CMP: begin
               lt_sf <= lt_nx;
               gt_sf <= gt_nx;
               cnt   <= cnt - CW'(1);
`ifdef SERIAL_CMP_EARLY_DONE_EN
               if (first_diff) begin
                  Done <= 1'b1;
                  LT   <= lt_nx;
                  EQ   <= 1'b0;
                  GT   <= gt_nx;
                  Swap <= gt_nx;
               end
               // Stay in CMP to track the serializer; a result already reported ends silently.
               if (cnt == '0) begin
                  Busy <= 1'b0;
                  if (!undecided) begin
                     state <= IDLE;
                  end else begin
                     state <= DONE;
                     Done  <= 1'b1;
                     LT    <= lt_nx;
                     EQ    <= ~(lt_nx | gt_nx);
                     GT    <= gt_nx;
                     Swap  <= gt_nx;
                  end
               end
`else
               if (cnt == '0) begin
                  state <= DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  LT    <= lt_nx;
                  EQ    <= ~(lt_nx | gt_nx);
                  GT    <= gt_nx;
                  Swap  <= gt_nx;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_char_compare.sv
// Directed bench for serial_char_compare; follows SERIAL_CMP_EARLY_DONE_EN if defined.
module tb_serial_char_compare;

   logic       CLK = 1'b0;
   logic       RST;
   logic       St;
   logic       R;
   logic       x;
   logic       y;
   logic       Busy;
   logic       Done;
   logic       LT;
   logic       EQ;
   logic       GT;
   logic       Swap;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   serial_char_compare #(.W(8)) dut (
      .CLK(CLK), .RST(RST), .St(St), .R(R), .x(x), .y(y),
      .Busy(Busy), .Done(Done), .LT(LT), .EQ(EQ), .GT(GT), .Swap(Swap),
      .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   // Edge after which Done is expected (E0 = start edge).
   function automatic int exp_done_edge(input logic [7:0] a, input logic [7:0] b);
      int e;
      e = 8;
`ifdef SERIAL_CMP_EARLY_DONE_EN
      for (int i = 7; i >= 0; i--) begin
         if (a[i] != b[i]) begin
            e = 8 - i;
            break;
         end
      end
`endif
      return e;
   endfunction

   // Inputs change on the falling edge; outputs are observed on the falling edge before the change.
   task automatic run_pair(input logic [7:0] xv, input logic [7:0] yv,
                           input int sa, input int sb, input logic st_at_done,
                           output int n_done, output int done_edge, output int busy_cnt,
                           output int held_bad, output int onehot_bad);
      logic [2:0] prev;
      n_done = 0; done_edge = -1; busy_cnt = 0; held_bad = 0; onehot_bad = 0;
      @(negedge CLK);
      prev = {LT, EQ, GT};
      St = 1'b1;
      R  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLK);
         if (Busy) busy_cnt++;
         if (Done) begin
            n_done++;
            if (done_edge < 0) done_edge = k - 1;
         end
         if (n_done == 0 && {LT, EQ, GT} !== prev) held_bad++;
         if (!$onehot({LT, EQ, GT})) onehot_bad++;
         St = (k == sa) || (k == sb) || ((k == 9) && st_at_done);
         if (k <= 8) begin
            x = xv[8-k];
            y = yv[8-k];
         end else begin
            x = ~x;
            y = x;
         end
      end
      St = 1'b0;
   endtask

   task automatic check_pair(input string name, input logic [7:0] xv, input logic [7:0] yv,
                             input int sa, input int sb, input logic st_at_done);
      int n_done, done_edge, busy_cnt, held_bad, onehot_bad;
      logic [3:0] exp_flags;
      run_pair(xv, yv, sa, sb, st_at_done, n_done, done_edge, busy_cnt, held_bad, onehot_bad);
      exp_flags = (xv < yv) ? 4'b1000 : (xv == yv) ? 4'b0100 : 4'b0011;
      checks++;
      if ({LT, EQ, GT, Swap} !== exp_flags) begin
         errors++;
         $display("FAIL %s flags LT/EQ/GT/Swap got %b want %b", name, {LT, EQ, GT, Swap}, exp_flags);
      end
      checks++;
      if (n_done !== 1) begin
         errors++;
         $display("FAIL %s done_count got %0d want 1", name, n_done);
      end
      checks++;
      if (done_edge !== exp_done_edge(xv, yv)) begin
         errors++;
         $display("FAIL %s done_edge got %0d want %0d", name, done_edge, exp_done_edge(xv, yv));
      end
      checks++;
      if (busy_cnt !== 8) begin
         errors++;
         $display("FAIL %s busy_cycles got %0d want 8", name, busy_cnt);
      end
      checks++;
      if (held_bad !== 0 || onehot_bad !== 0) begin
         errors++;
         $display("FAIL %s hold/onehot got held_bad=%0d onehot_bad=%0d want 0/0", name, held_bad, onehot_bad);
      end
   endtask

   task automatic test_reset;
      RST = 1'b1; St = 1'b0; R = 1'b0; x = 1'b0; y = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if ({Busy, Done, LT, EQ, GT, Swap, state_dbg} !== 8'b00_0100_00) begin
         errors++;
         $display("FAIL reset_values got %b want %b", {Busy, Done, LT, EQ, GT, Swap, state_dbg}, 8'b00010000);
      end
      RST = 1'b0;
   endtask

   task automatic test_basic;
      check_pair("a_vs_b", 8'h61, 8'h62, 0, 0, 1'b0);
      check_pair("Z_vs_A", 8'h5A, 8'h41, 0, 0, 1'b0);
      check_pair("A_vs_A", 8'h41, 8'h41, 0, 0, 1'b0);
   endtask

   task automatic test_st_while_busy;
      check_pair("00_vs_FF_stpulses", 8'h00, 8'hFF, 3, 5, 1'b0);
      check_pair("FF_vs_00_hold", 8'hFF, 8'h00, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back;
      // St&R during the Done cycle must not start a new comparison (busy_cnt would read 9).
      check_pair("st_in_done_cycle", 8'h30, 8'h31, 0, 0, 1'b1);
      check_pair("back_to_back", 8'h7E, 8'h7E, 0, 0, 1'b0);
   endtask

   task automatic test_mid_reset;
      logic [7:0] xv, yv;
      int n_done;
      xv = 8'h7A; yv = 8'h20;
      @(negedge CLK);
      St = 1'b1; R = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         St = 1'b0;
         x = xv[8-k];
         y = yv[8-k];
         if (k == 4) RST = 1'b1;
      end
      @(negedge CLK);
      RST = 1'b0;
      checks++;
      if ({Busy, Done, LT, EQ, GT, Swap, state_dbg} !== 8'b00_0100_00) begin
         errors++;
         $display("FAIL mid_reset state got %b want %b", {Busy, Done, LT, EQ, GT, Swap, state_dbg}, 8'b00010000);
      end
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         x = ~x;
         if (Done || Busy) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL mid_reset_quiet got %0d active cycles want 0", n_done);
      end
      check_pair("after_reset_20_vs_7A", 8'h20, 8'h7A, 0, 0, 1'b0);
   endtask

   task automatic test_not_ready;
      int busy_seen;
      busy_seen = 0;
      @(negedge CLK);
      St = 1'b1; R = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         if (Busy || state_dbg != 2'd0) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin
         errors++;
         $display("FAIL not_ready_idle got %0d busy cycles want 0", busy_seen);
      end
      St = 1'b0;
      check_pair("ready_start_42_vs_24", 8'h42, 8'h24, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_st_while_busy();
      test_back_to_back();
      test_mid_reset();
      test_not_ready();
      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
